mac_sched: RTL and testbench

MAC_SCHED -- requirements
Module: mac_sched

---
 rtl/mac_sched.sv | 129 ++++++++++++
 tb/tb_mac_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sched.sv
// Two-requester round-robin burst scheduler with a multiply-accumulate datapath.
// The last product lands one cycle after the final beat, and done pulses two cycles after that beat.
module mac_sched (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [7:0] req_len,
  input  logic [1:0] op_valid,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic [1:0] op_ready,
  output logic [1:0] gnt,
  output logic       busy,
  output logic [1:0] done,
  output logic [9:0] result0,
  output logic [9:0] result1,
  output logic [1:0] ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        last_g;
  logic [3:0]  len_q, cnt;
  logic [7:0]  prod;
  logic        prod_vld;
  logic [9:0]  acc;
  logic        ovf_int;
  logic [1:0]  win;
  logic        gi;
  logic        accept;
  logic [3:0]  sel_a, sel_b;
  logic [10:0] sum;
  logic [9:0]  sat;
  logic [9:0]  fin;
  logic        fin_ovf;

  assign gi     = gnt[1];
  assign sel_a  = gi ? op_a[7:4] : op_a[3:0];
  assign sel_b  = gi ? op_b[7:4] : op_b[3:0];
  assign accept = |(op_valid & op_ready);
  assign sum    = {1'b0, acc} + {3'b000, prod};
  assign sat    = sum[10] ? 10'd1023 : sum[9:0];

  // The final product is still in flight while DRAIN exits, so fold it in here.
  assign fin     = prod_vld ? sat : acc;
  assign fin_ovf = ovf_int | (prod_vld & sum[10]);

  // last_g names the requester served most recently; the other one wins a tie.
  always_comb begin
    win = req;
    if (req == 2'b11)
      win = last_g ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_RUN;
      S_RUN:   if (accept && (cnt == len_q)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (state == S_RUN) ? gnt : 2'b00;
    done     = (state == S_DONE) ? gnt : 2'b00;
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= 2'b00;
      last_g   <= 1'b1;
      len_q    <= 4'd0;
      cnt      <= 4'd0;
      prod     <= 8'd0;
      prod_vld <= 1'b0;
      acc      <= 10'd0;
      ovf_int  <= 1'b0;
      result0  <= 10'd0;
      result1  <= 10'd0;
      ovf      <= 2'b00;
    end else begin
      prod_vld <= accept;
      if (accept) begin
        prod <= {4'b0000, sel_a} * {4'b0000, sel_b};
        cnt  <= cnt + 4'd1;
      end
      if (prod_vld) begin
        acc     <= sat;
        ovf_int <= ovf_int | sum[10];
      end
      case (state)
        S_IDLE: if (|req) begin
          gnt     <= win;
          len_q   <= win[1] ? req_len[7:4] : req_len[3:0];
          acc     <= 10'd0;
          cnt     <= 4'd0;
          ovf_int <= 1'b0;
        end
        S_DRAIN: begin
          if (gi) begin
            result1 <= fin;
            ovf[1]  <= fin_ovf;
          end else begin
            result0 <= fin;
            ovf[0]  <= fin_ovf;
          end
        end
        S_DONE: begin
          last_g <= gi;
          gnt    <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
// Bench for mac_sched: hand sequences, a vector table and randomized bursts checked against a sum-of-products model.
module tb_mac_sched;

  logic       clk;
  logic       reset_n;
  logic [1:0] req;
  logic [7:0] req_len;
  logic [1:0] op_valid;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] op_ready;
  logic [1:0] gnt;
  logic       busy;
  logic [1:0] done;
  logic [9:0] result0;
  logic [9:0] result1;
  logic [1:0] ovf;

  mac_sched dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_len  (req_len),
    .op_valid (op_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_ready (op_ready),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .result0  (result0),
    .result1  (result1),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: operands of the next burst, per-requester result, and who was served last.
  int opa [16];
  int opb [16];
  int exp_res [2];
  bit exp_ovf [2];
  int last;

  typedef struct {
    logic [1:0] rq;
    int         len;
    int         stall_at;
    int         stall_n;
    bit         hold;
    int         exp_g;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask

  // Entered and left at a falling edge with the FSM in IDLE.
  task automatic burst(input logic [1:0] rq, input int len, input int exp_g,
                       input int stall_at, input int stall_n, input bit hold);
    int sum;
    int o;
    logic [1:0] gm;
    gm  = 2'b01 << exp_g;
    o   = 1 - exp_g;
    sum = 0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_gnt", 32'(gnt), 0);
    req     = rq;
    req_len = {4'(len), 4'(len)};
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(gm));
    chk("run_busy", 32'(busy), 1);
    if (!hold) req = 2'b00;
    req_len = 8'($urandom);
    for (int k = 0; k <= len; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          op_valid = 2'b00;
          op_valid[o] = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("stall_rdy", 32'(op_ready), 32'(gm));
        end
      end
      chk("beat_rdy", 32'(op_ready), 32'(gm));
      sum += opa[k] * opb[k];
      op_valid[exp_g] = 1'b1;
      op_valid[o]     = 1'($urandom_range(0, 1));
      op_a[exp_g*4 +: 4] = 4'(opa[k]);
      op_b[exp_g*4 +: 4] = 4'(opb[k]);
      op_a[o*4 +: 4]     = 4'($urandom);
      op_b[o*4 +: 4]     = 4'($urandom);
      @(negedge clk);
    end
    op_valid = 2'b00;
    chk("drain_rdy", 32'(op_ready), 0);
    chk("drain_done", 32'(done), 0);
    @(negedge clk);
    exp_res[exp_g] = (sum > 1023) ? 1023 : sum;
    exp_ovf[exp_g] = (sum > 1023);
    last = exp_g;
    chk("done", 32'(done), 32'(gm));
    chk("result0", 32'(result0), 32'(exp_res[0]));
    chk("result1", 32'(result1), 32'(exp_res[1]));
    chk("ovf", 32'(ovf), {30'd0, exp_ovf[1], exp_ovf[0]});
    @(negedge clk);
    chk("done_clr", 32'(done), 0);
    chk("gnt_clr", 32'(gnt), 0);
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 16; k++) begin
      opa[k] = int'($urandom_range(0, 15));
      opb[k] = int'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r_save;
    logic [1:0] rq;
    int len;
    int eg;

    // rq, len, stall_at, stall_n, hold, expected grant
    tbl[0] = '{2'b11, 0, 99, 0, 1'b1, 0};
    tbl[1] = '{2'b11, 0, 99, 0, 1'b1, 1};
    tbl[2] = '{2'b11, 0, 99, 0, 1'b1, 0};
    tbl[3] = '{2'b11, 0, 99, 0, 1'b1, 1};
    tbl[4] = '{2'b10, 2, 1, 2, 1'b0, 1};
    tbl[5] = '{2'b11, 3, 2, 3, 1'b0, 0};
    tbl[6] = '{2'b11, 1, 99, 0, 1'b0, 1};
    tbl[7] = '{2'b01, 4, 0, 1, 1'b1, 0};

    reset_n = 1'b0; req = 2'b00; req_len = 8'h00;
    op_valid = 2'b00; op_a = 8'h00; op_b = 8'h00;
    exp_res[0] = 0; exp_res[1] = 0; exp_ovf[0] = 0; exp_ovf[1] = 0; last = 1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rdy", 32'(op_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res0", 32'(result0), 0);
    chk("rst_res1", 32'(result1), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Four-beat burst on requester 0: 12+30+56+1.
    opa[0] = 3; opb[0] = 4; opa[1] = 5; opb[1] = 6;
    opa[2] = 7; opb[2] = 8; opa[3] = 1; opb[3] = 1;
    burst(2'b01, 3, 0, 99, 0, 1'b0);
    chk("single_res0", 32'(result0), 99);
    chk("single_ovf0", 32'(ovf[0]), 0);

    // Saturation on requester 1, then a small burst clears the flag.
    for (int k = 0; k < 16; k++) begin opa[k] = 15; opb[k] = 15; end
    burst(2'b10, 15, 1, 99, 0, 1'b0);
    chk("sat_res1", 32'(result1), 1023);
    chk("sat_ovf1", 32'(ovf[1]), 1);
    opa[0] = 2; opb[0] = 2;
    burst(2'b10, 0, 1, 99, 0, 1'b0);
    chk("after_sat_res1", 32'(result1), 4);
    chk("after_sat_ovf1", 32'(ovf[1]), 0);
    chk("res0_held", 32'(result0), 99);

    // Same operands with and without a 3-cycle valid gap.
    rand_ops();
    burst(2'b01, 5, 0, 99, 0, 1'b0);
    r_save = int'(result0);
    burst(2'b01, 5, 0, 2, 3, 1'b0);
    chk("stall_same_sum", 32'(result0), 32'(r_save));

    // Reset in the middle of a burst.
    req = 2'b01; req_len = 8'h55;
    @(negedge clk);
    req = 2'b00; op_valid = 2'b01; op_a = 8'h09; op_b = 8'h09;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_rdy", 32'(op_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_res0", 32'(result0), 0);
    chk("mid_rst_res1", 32'(result1), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    exp_res[0] = 0; exp_res[1] = 0; exp_ovf[0] = 0; exp_ovf[1] = 0; last = 1;
    op_valid = 2'b00;
    @(negedge clk);
    chk("mid_rst_no_done", 32'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      rand_ops();
      burst(tbl[i].rq, tbl[i].len, tbl[i].exp_g, tbl[i].stall_at, tbl[i].stall_n, tbl[i].hold);
    end
    req = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      rand_ops();
      rq  = 2'($urandom_range(1, 3));
      len = int'($urandom_range(0, 15));
      if (rq == 2'b11) eg = (last == 1) ? 0 : 1;
      else eg = (rq == 2'b10) ? 1 : 0;
      burst(rq, len, eg, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
